// File: rtl/alu_issue_seq_pkg.sv
// Shared op-kind codes, ALU opcodes and FSM states for the ALU issue sequencer.
package alu_issue_seq_pkg;

  typedef enum logic [2:0] {
    KIND_AND = 3'd0,
    KIND_ADD = 3'd1,
    KIND_SUB = 3'd2,
    KIND_BEQ = 3'd3,
    KIND_BNE = 3'd4,
    KIND_BGT = 3'd5,
    KIND_BLT = 3'd6,
    KIND_NOP = 3'd7
  } kind_e;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Branches compare by subtraction so their flags come straight from the ALU.
  function automatic logic [2:0] kindToAluOp(input logic [2:0] kind);
    case (kind_e'(kind))
      KIND_AND, KIND_NOP: return ALU_AND;
      KIND_ADD:           return ALU_ADD;
      default:            return ALU_SUB;
    endcase
  endfunction

  function automatic logic kindWritesReg(input logic [2:0] kind);
    return (kind_e'(kind) == KIND_AND) || (kind_e'(kind) == KIND_ADD) ||
           (kind_e'(kind) == KIND_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_seq_branch_resolve.sv
// Combinational branch decision from an op kind and the captured zero/negative flags.
module alu_issue_seq_branch_resolve
  import alu_issue_seq_pkg::*;
(
  input  logic [2:0] i_kind,
  input  logic       i_zero,
  input  logic       i_neg,
  output logic       o_is_branch,
  output logic       o_take
);

  // Overflow is deliberately ignored: BGT/BLT trust the sign of a-b.
  always_comb begin
    o_is_branch = 1'b0;
    o_take      = 1'b0;
    case (kind_e'(i_kind))
      KIND_BEQ: begin o_is_branch = 1'b1; o_take = i_zero;            end
      KIND_BNE: begin o_is_branch = 1'b1; o_take = !i_zero;           end
      KIND_BGT: begin o_is_branch = 1'b1; o_take = !i_zero && !i_neg; end
      KIND_BLT: begin o_is_branch = 1'b1; o_take = i_neg;             end
      default:  begin o_is_branch = 1'b0; o_take = 1'b0;              end
    endcase
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Execute-stage sequencer: issues one op to the ALU, waits out its latency,
// captures the result and flags, resolves branches and hands off to writeback.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int W           = 32,
  parameter int ALU_LATENCY = 1,
  parameter int TAG_W       = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_kind,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_op,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_wr_en,
  output logic             out_is_branch,
  output logic             out_take,
  output logic             flag_z,
  output logic             flag_n
);

  localparam logic [1:0] LAT_LOAD = 2'(ALU_LATENCY);

  state_e           r_state;
  state_e           w_nextState;
  logic [1:0]       r_cnt;
  logic [2:0]       r_kind;
  logic [TAG_W-1:0] r_tag;
  logic             w_done;
  logic             w_accept;
  logic             w_capture;
  logic             w_isBranch;
  logic             w_take;

  assign w_done    = (r_state == ST_DONE);
  assign in_ready  = !reset && ((r_state == ST_IDLE) || (w_done && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign w_capture = (r_state == ST_WAIT) && (r_cnt == 2'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // A new op offered while the result drains goes straight back to WAIT.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_nextState = ST_WAIT;
      ST_WAIT: if (w_capture) w_nextState = ST_DONE;
      ST_DONE: if (out_ready) w_nextState = w_accept ? ST_WAIT : ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_kind <= 3'd0;
      r_tag  <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= ALU_AND;
    end else if (w_accept) begin
      r_kind <= in_kind;
      r_tag  <= in_tag;
      alu_a  <= in_a;
      alu_b  <= in_b;
      alu_op <= kindToAluOp(in_kind);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                     r_cnt <= 2'd0;
    else if (w_accept)                             r_cnt <= LAT_LOAD;
    else if (r_state == ST_WAIT && r_cnt != 2'd0)  r_cnt <= r_cnt - 2'd1;
  end

  // Flags are sticky: they only move when a result is captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_result <= '0;
      out_tag    <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
    end else if (w_capture) begin
      out_result <= alu_out;
      out_tag    <= r_tag;
      flag_z     <= alu_zero;
      flag_n     <= alu_neg;
    end
  end

  alu_issue_seq_branch_resolve u_branch (
    .i_kind      (r_kind),
    .i_zero      (flag_z),
    .i_neg       (flag_n),
    .o_is_branch (w_isBranch),
    .o_take      (w_take)
  );

  assign out_valid     = w_done;
  assign out_wr_en     = w_done && kindWritesReg(r_kind);
  assign out_is_branch = w_done && w_isBranch;
  assign out_take      = w_done && w_take;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Randomized self-checking bench for alu_issue_seq with behavioural ALUs at latencies 1, 0 and 3.
module tb_alu_issue_seq;
  import alu_issue_seq_pkg::*;

  localparam int W = 32;
  localparam int LATS [3] = '{1, 0, 3};

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [2:0]   tag;
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         wr;
    logic         br;
    logic         take;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic         inValidV    [3];
  logic         inReadyV    [3];
  logic [2:0]   inKindV     [3];
  logic [W-1:0] inAV        [3];
  logic [W-1:0] inBV        [3];
  logic [2:0]   inTagV      [3];
  logic [W-1:0] aluAV       [3];
  logic [W-1:0] aluBV       [3];
  logic [2:0]   aluOpV      [3];
  logic [W-1:0] aluOutV     [3];
  logic         aluZeroV    [3];
  logic         aluNegV     [3];
  logic         outValidV   [3];
  logic         outReadyV   [3];
  logic [W-1:0] outResultV  [3];
  logic [2:0]   outTagV     [3];
  logic         outWrEnV    [3];
  logic         outIsBranchV[3];
  logic         outTakeV    [3];
  logic         flagZV      [3];
  logic         flagNV      [3];

  exp_t expQ[$];
  int   testCount = 0;
  int   failCount = 0;
  int   waited;

  always #5 clock = ~clock;

  // Stand-in for the real ALU: combinational result delayed by LATS[g] clock edges.
  function automatic logic [W+1:0] aluCompute(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] op);
    logic [W-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      default: r = a & b;
    endcase
    return {r[W-1], (r == '0), r};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gDut
    logic [W+1:0] s0, s1, s2, s3, sel;
    assign s0 = aluCompute(aluAV[g], aluBV[g], aluOpV[g]);
    always_ff @(posedge clock) begin
      s1 <= s0;
      s2 <= s1;
      s3 <= s2;
    end
    assign sel = (LATS[g] == 0) ? s0 : (LATS[g] == 1) ? s1 : (LATS[g] == 2) ? s2 : s3;
    assign aluNegV[g]  = sel[W+1];
    assign aluZeroV[g] = sel[W];
    assign aluOutV[g]  = sel[W-1:0];

    alu_issue_seq #(.W(W), .ALU_LATENCY(LATS[g]), .TAG_W(3)) uDut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (inValidV[g]),
      .in_ready      (inReadyV[g]),
      .in_kind       (inKindV[g]),
      .in_a          (inAV[g]),
      .in_b          (inBV[g]),
      .in_tag        (inTagV[g]),
      .alu_a         (aluAV[g]),
      .alu_b         (aluBV[g]),
      .alu_op        (aluOpV[g]),
      .alu_out       (aluOutV[g]),
      .alu_zero      (aluZeroV[g]),
      .alu_neg       (aluNegV[g]),
      .out_valid     (outValidV[g]),
      .out_ready     (outReadyV[g]),
      .out_result    (outResultV[g]),
      .out_tag       (outTagV[g]),
      .out_wr_en     (outWrEnV[g]),
      .out_is_branch (outIsBranchV[g]),
      .out_take      (outTakeV[g]),
      .flag_z        (flagZV[g]),
      .flag_n        (flagNV[g])
    );
  end

  // Reference: what an op means architecturally, computed directly from its kind.
  function automatic exp_t refModel(input logic [2:0] kind, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [2:0] tag);
    exp_t e;
    e.a = a;
    e.b = b;
    e.tag = tag;
    if (kind == KIND_AND || kind == KIND_NOP) begin e.res = a & b; e.op = ALU_AND; end
    else if (kind == KIND_ADD)                begin e.res = a + b; e.op = ALU_ADD; end
    else                                      begin e.res = a - b; e.op = ALU_SUB; end
    e.z    = (e.res == '0);
    e.n    = e.res[W-1];
    e.wr   = kind inside {KIND_AND, KIND_ADD, KIND_SUB};
    e.br   = kind inside {KIND_BEQ, KIND_BNE, KIND_BGT, KIND_BLT};
    e.take = (kind == KIND_BEQ && e.z) || (kind == KIND_BNE && !e.z) ||
             (kind == KIND_BGT && !e.z && !e.n) || (kind == KIND_BLT && e.n);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    testCount++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Offer an op and return at the negedge after the accepting edge.
  task automatic applyStimulus(input int d, input logic [2:0] kind, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [2:0] tag, output int n);
    n = 0;
    inValidV[d] = 1'b1;
    inKindV[d]  = kind;
    inAV[d]     = a;
    inBV[d]     = b;
    inTagV[d]   = tag;
    #1;
    while (!inReadyV[d] && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    checkOutput("acceptReady", inReadyV[d], 1'b1);
    expQ.push_back(refModel(kind, a, b, tag));
    @(posedge clock);
    @(negedge clock);
    inValidV[d] = 1'b0;
    inKindV[d]  = 3'($urandom);
    inAV[d]     = $urandom;
    inBV[d]     = $urandom;
    inTagV[d]   = 3'($urandom);
  endtask

  task automatic waitAndCheck(input int d, input int lat, input int hold);
    exp_t e;
    int   n;
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 64'd0, 64'd1);
      return;
    end
    e = expQ.pop_front();
    n = 1;
    while (!outValidV[d] && n < 20) begin
      checkOutput("aluAHeld", aluAV[d], e.a);
      checkOutput("aluBHeld", aluBV[d], e.b);
      checkOutput("aluOpHeld", aluOpV[d], e.op);
      @(negedge clock);
      n++;
    end
    checkOutput("latency", n, 2 + lat);
    checkOutput("result", outResultV[d], e.res);
    checkOutput("tag", outTagV[d], e.tag);
    checkOutput("wrEn", outWrEnV[d], e.wr);
    checkOutput("isBranch", outIsBranchV[d], e.br);
    checkOutput("take", outTakeV[d], e.take);
    checkOutput("flagZ", flagZV[d], e.z);
    checkOutput("flagN", flagNV[d], e.n);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checkOutput("holdValid", outValidV[d], 1'b1);
      checkOutput("holdResult", outResultV[d], e.res);
      checkOutput("holdTag", outTagV[d], e.tag);
      checkOutput("holdInReady", inReadyV[d], 1'b0);
    end
  endtask

  task automatic drainOutput(input int d);
    outReadyV[d] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    outReadyV[d] = 1'b0;
    #1;
    checkOutput("drainValid", outValidV[d], 1'b0);
    checkOutput("drainInReady", inReadyV[d], 1'b1);
    checkOutput("gatedWrEn", outWrEnV[d], 1'b0);
    checkOutput("gatedBranch", outIsBranchV[d], 1'b0);
    checkOutput("gatedTake", outTakeV[d], 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]   k;
    logic [W-1:0] a, b;

    for (int d = 0; d < 3; d++) begin
      inValidV[d]  = 1'b0;
      inKindV[d]   = 3'd0;
      inAV[d]      = '0;
      inBV[d]      = '0;
      inTagV[d]    = 3'd0;
      outReadyV[d] = 1'b0;
    end
    repeat (2) @(negedge clock);
    checkOutput("rstInReady", inReadyV[0], 1'b0);
    checkOutput("rstOutValid", outValidV[0], 1'b0);
    checkOutput("rstAluA", aluAV[0], '0);
    checkOutput("rstAluOp", aluOpV[0], ALU_AND);
    checkOutput("rstResult", outResultV[0], '0);
    checkOutput("rstFlagZ", flagZV[0], 1'b0);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) checkOutput("relInReady", inReadyV[d], 1'b1);

    // Directed ops from the block's intended use.
    applyStimulus(0, KIND_AND, 32'd10, 32'd20, 3'd2, waited);
    waitAndCheck(0, 1, 0);
    drainOutput(0);
    applyStimulus(0, KIND_ADD, 32'd30, 32'd20, 3'd1, waited);
    waitAndCheck(0, 1, 1);
    drainOutput(0);
    applyStimulus(0, KIND_SUB, 32'hFFF, 32'hF0F, 3'd3, waited);
    waitAndCheck(0, 1, 0);
    drainOutput(0);
    applyStimulus(0, KIND_BLT, 32'd5, 32'd9, 3'd4, waited);
    waitAndCheck(0, 1, 0);
    checkOutput("bltFixedResult", outResultV[0], 32'hFFFF_FFFC);
    drainOutput(0);
    applyStimulus(0, KIND_BEQ, 32'd7, 32'd7, 3'd5, waited);
    waitAndCheck(0, 1, 0);
    drainOutput(0);
    applyStimulus(0, KIND_BGT, 32'd7, 32'd7, 3'd6, waited);
    waitAndCheck(0, 1, 0);
    drainOutput(0);

    for (int i = 0; i < 40; i++) begin
      k = 3'($urandom_range(0, 7));
      a = (i % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = W'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      applyStimulus(0, k, a, b, 3'($urandom), waited);
      waitAndCheck(0, 1, $urandom_range(0, 3));
      drainOutput(0);
    end

    // Back-pressure, then a new op accepted on the draining edge.
    applyStimulus(0, KIND_ADD, 32'd100, 32'd23, 3'd4, waited);
    waitAndCheck(0, 1, 4);
    outReadyV[0] = 1'b1;
    applyStimulus(0, KIND_SUB, 32'd5, 32'd9, 3'd6, waited);
    outReadyV[0] = 1'b0;
    checkOutput("noBubbleWait", waited, 0);
    checkOutput("chainValidDrop", outValidV[0], 1'b0);
    checkOutput("chainAluA", aluAV[0], 32'd5);
    waitAndCheck(0, 1, 0);
    drainOutput(0);

    // Reset while an op sits in WAIT.
    applyStimulus(0, KIND_ADD, 32'd30, 32'd20, 3'd5, waited);
    void'(expQ.pop_back());
    reset = 1'b1;
    #1;
    checkOutput("midRstValid", outValidV[0], 1'b0);
    checkOutput("midRstInReady", inReadyV[0], 1'b0);
    checkOutput("midRstAluA", aluAV[0], '0);
    checkOutput("midRstAluOp", aluOpV[0], ALU_AND);
    checkOutput("midRstResult", outResultV[0], '0);
    checkOutput("midRstFlagN", flagNV[0], 1'b0);
    checkOutput("midRstFlagZ", flagZV[0], 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("postRstInReady", inReadyV[0], 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("postRstNoValid", outValidV[0], 1'b0);
    end
    applyStimulus(0, KIND_ADD, 32'd30, 32'd20, 3'd7, waited);
    waitAndCheck(0, 1, 0);
    drainOutput(0);

    // Same ADD on the latency-0 and latency-3 instances.
    applyStimulus(1, KIND_ADD, 32'd30, 32'd20, 3'd1, waited);
    waitAndCheck(1, 0, 1);
    drainOutput(1);
    applyStimulus(2, KIND_ADD, 32'd30, 32'd20, 3'd2, waited);
    waitAndCheck(2, 3, 1);
    drainOutput(2);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
